// File: rtl/chu_spi_slave_core.sv
// SPI mode-0 responder core for one FPro MMIO slot: 8-bit frames, MSB first, all SPI pins oversampled by clk.
// Build option SPI_SLV_ECHO_EN: an empty TX buffer transmits the last received byte instead of 0xFF.
module chu_spi_slave_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_next;
  logic        sclk_p0, sclk_p1, sclk_p2;
  logic        mosi_p0, mosi_p1, mosi_p2;
  logic        ss_p0, ss_p1, ss_p2;
  logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic        load_en, sample_en, shift_en, frame_done;
  logic        wr_tx, wr_clr;
  logic [7:0]  shift_reg, rx_data, tx_buf, fill_byte, load_byte;
  logic [3:0]  bit_cnt;
  logic        mosi_bit, rx_valid, tx_full, overrun;
  logic        unused_bits;

  // Stage p0/p1: two-flop synchronizers; stage p2: history flop for edge detection.
  // ss_n resets low so a master still selecting us across reset never looks like a fresh select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0; mosi_p1 <= 1'b0; mosi_p2 <= 1'b0;
      ss_p0   <= 1'b0; ss_p1   <= 1'b0; ss_p2   <= 1'b0;
    end else begin
      sclk_p0 <= spi_sclk; sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
      mosi_p0 <= spi_mosi; mosi_p1 <= mosi_p0; mosi_p2 <= mosi_p1;
      ss_p0   <= spi_ss_n; ss_p1   <= ss_p0;   ss_p2   <= ss_p1;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign ss_fall   = ~ss_p1 & ss_p2;
  assign ss_rise   = ss_p1 & ~ss_p2;

  assign wr_tx  = cs & write & (addr == 5'd1);
  assign wr_clr = cs & write & (addr == 5'd2);

`ifdef SPI_SLV_ECHO_EN
  assign fill_byte = rx_data;
`else
  assign fill_byte = 8'hFF;
`endif

  assign load_byte  = tx_full ? tx_buf : fill_byte;
  assign frame_done = sample_en & (bit_cnt == 4'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          load_en    = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_next = IDLE;
        end else if (sclk_rise) begin
          sample_en = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt == 4'd8) load_en  = 1'b1;
          else                 shift_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The sampled bit is held in mosi_bit until the falling edge so the outgoing LSB is not overwritten early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 4'd0;
      mosi_bit  <= 1'b0;
    end else if (load_en) begin
      shift_reg <= load_byte;
      bit_cnt   <= 4'd0;
    end else if (sample_en) begin
      mosi_bit  <= mosi_p2;
      bit_cnt   <= bit_cnt + 4'd1;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[6:0], mosi_bit};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
    end else begin
      if (wr_tx)        tx_buf  <= wr_data[7:0];
      if (wr_tx)        tx_full <= 1'b1;
      else if (load_en) tx_full <= 1'b0;
    end
  end

  // Frame completion takes priority over a simultaneous CLR for rx_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (frame_done) rx_data <= {shift_reg[6:0], mosi_p2};
      if (frame_done)  rx_valid <= 1'b1;
      else if (wr_clr) rx_valid <= 1'b0;
      if (wr_clr)                      overrun <= 1'b0;
      else if (frame_done && rx_valid) overrun <= 1'b1;
    end
  end

  assign spi_miso = (state == SHIFT) & shift_reg[7];

  always_comb begin
    rd_data = 32'd0;
    if (cs && addr == 5'd0)
      rd_data = {20'd0, (state == SHIFT), overrun, ~tx_full, rx_valid, rx_data};
  end

  assign unused_bits = ^{read, wr_data[31:8]};

endmodule

// File: doc/chu_spi_slave_core.md
# chu_spi_slave_core

SPI responder (slave) MMIO core for the FPro bus: the far-end counterpart of the SPI master cores already used in our designs, occupying one slot of the MMIO subsystem. It receives 8-bit SPI mode-0 frames from an external master, returns a CPU-loaded byte on MISO, and exposes the data and status through three slot registers. All SPI inputs are oversampled in the system clock domain.

## Interface
- No parameters; frame length fixed at 8 bits, MSB first, CPOL=0, CPHA=0.
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- cs  in  1  slot select
- read  in  1  read strobe; registers have no read side effects
- write  in  1  write strobe, qualified by cs
- addr  in  5  register word address
- wr_data  in  32  write data
- rd_data  out  32  combinational read data
- spi_sclk  in  1  serial clock from master
- spi_mosi  in  1  master-out data
- spi_ss_n  in  1  active-low select from master
- spi_miso  out  1  slave-out data

## Operation
- Registers:
  - addr 0, read STATUS/RX: [7:0] rx_data, [8] rx_valid, [9] tx_empty, [10] overrun, [11] busy, rest 0.
  - addr 1, write TX: loads wr_data[7:0] into tx_buf and sets tx_full.
  - addr 2, write CLR: any write clears rx_valid and overrun.
  - Other addresses read 0, and writes to them are ignored.
- Synchronizers: spi_sclk, spi_mosi and spi_ss_n each pass through 2 flip-flops plus one history flip-flop.
- Edge detection is done on the synchronized signals: sclk rise, sclk fall, ss_n fall, ss_n rise.
- FSM states:
  - IDLE -> SHIFT on ss_n fall. The shift register is loaded with tx_buf if tx_full, otherwise 0xFF. tx_full clears, bit_cnt=0 and busy=1.
  - SHIFT, on sclk rise: sample mosi into the shift LSB and increment bit_cnt.
    - When bit_cnt reaches 8, copy the received byte to rx_data. Set overrun if rx_valid was already 1 (rx_data is still overwritten), then set rx_valid=1.
  - SHIFT, on sclk fall:
    - If 8 bits have completed, reload the shift register from tx_buf or 0xFF and set bit_cnt=0 (back-to-back frame).
    - Otherwise shift left.
  - SHIFT -> IDLE on ss_n rise at any point. A partial frame is discarded and rx_valid/rx_data are unchanged. The byte already loaded stays consumed. busy=0.
- spi_miso: shift register MSB while in SHIFT; 0 in IDLE.
- A CPU write to TX in the same cycle as a load/reload: the load uses the pre-write tx_buf/tx_full state, and the new byte is stored with tx_full=1.
- A CLR write in the same cycle as a frame completion: the completion wins, so rx_valid=1 (overrun is cleared).

## Timing
- Reset values:
  - FSM=IDLE, shift=0, bit_cnt=0, rx_data=0, rx_valid=0, tx_buf=0, tx_full=0, overrun=0.
  - spi_miso=0, rd_data=0 (nothing addressed).
- Input-to-action latency is 3 clk (2 synchronizer stages + edge register).
- The MSB appears on spi_miso 3 clk after the ss_n fall at the pins.
- Master constraints:
  - sclk high and low phases each ≥4 clk.
  - ≥4 clk from ss_n fall to the first sclk rise.
  - ≥4 clk from the last sclk fall to the ss_n rise.
- rx_valid rises 3 clk after the 8th sclk rise at the pin.
- Register writes take effect on the next clk edge. rd_data is combinational from registered state.

## Configuration
- SPI_SLV_ECHO_EN: when defined, a load with tx_full=0 transmits the last completed rx_data instead of 0xFF (echo/loopback mode).
- When undefined, the empty-buffer fill byte is 0xFF.
- The macro does not affect any other behaviour.

## Test plan
- Reset, then read addr 0 -> 0x0000_0200 (tx_empty=1 only); spi_miso=0.
- Write 0xA5 to addr 1; master sends 0x3C at sclk = clk/10 -> master receives 0xA5; addr 0 reads 0x0000_033C.
- Two back-to-back frames under one ss_n, 0x11 then 0x22, with no CLR -> rx_data=0x22, rx_valid=1, overrun=1. Write addr 2 -> status reads 0x0000_0222.
- Frame with tx empty -> master receives 0xFF. With SPI_SLV_ECHO_EN, after a prior rx of 0x5A, master receives 0x5A.
- ss_n deasserted after 5 bits -> rx_data/rx_valid unchanged and busy=0. The next full frame 0x81 is received correctly.
- Assert reset mid-frame -> all state returns to reset values immediately (asynchronous). After release with ss_n still low, the FSM stays IDLE until a fresh ss_n fall.
